// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - Breakout ball motion and wall/paddle/brick collision engine
//
// Advances the ball once per board-rate tick, reflects it off the screen
// walls, the paddle and the single brick, and reports brick hits and
// bottom-edge losses as one-clock pulses.
//
// Ports:
//   clk          100 MHz master clock
//   rst          synchronous reset, active low
//   tick         one-clock move enable at board rate
//   launch       debounced launch button (level)
//   paddle_x/_y  paddle left/top edge
//   brick_x/_y   brick left/top edge
//   brick_alive  brick present; brick collisions ignored when low
//   ball_x/_y    registered ball left/top edge
//   brick_hit    one-clock pulse after a tick that hit the brick
//   lost         one-clock pulse after a tick where the ball left the bottom
//   state        IDLE=0, MOVE=1, LOST=2
//
// Optional feature macro: BALL_SPEEDUP_EN (every 8th paddle bounce raises
// the speed by one, saturating at 2*SPEED).
module ball_motion #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_W   = 64,
    parameter int PADDLE_H   = 8,
    parameter int BRICK_W    = 64,
    parameter int BRICK_H    = 16,
    parameter int SPEED      = 2,
    parameter int LOST_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    input  logic [9:0] paddle_y,
    input  logic [9:0] brick_x,
    input  logic [9:0] brick_y,
    input  logic       brick_alive,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       brick_hit,
    output logic       lost,
    output logic [1:0] state
);
    localparam logic [10:0] W11      = 11'(SCREEN_W);
    localparam logic [10:0] H11      = 11'(SCREEN_H);
    localparam logic [10:0] B11      = 11'(BALL_SIZE);
    localparam logic [9:0]  B10      = 10'(BALL_SIZE);
    localparam logic [10:0] PW11     = 11'(PADDLE_W);
    localparam logic [10:0] PH11     = 11'(PADDLE_H);
    localparam logic [10:0] BW11     = 11'(BRICK_W);
    localparam logic [10:0] BH11     = 11'(BRICK_H);
    localparam logic [10:0] SPD11    = 11'(SPEED);
    localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]  Y_MAX10  = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] HALF_OFF = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam int          CNT_W    = $clog2(LOST_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOST_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_LOST = 2'd2
    } state_e;

    state_e           state_q;
    logic [9:0]       x_q, y_q;
    logic             dx_q;        // 1 = moving right
    logic             dy_q;        // 1 = moving down
    logic             hit_q, lost_q;
    logic [CNT_W-1:0] cnt_q;

    logic [10:0] spd;
`ifdef BALL_SPEEDUP_EN
    localparam logic [10:0] SPD_MAX = 11'(2 * SPEED);
    logic [10:0] speed_q;
    logic [2:0]  bounce_q;
    assign spd = speed_q;
`else
    assign spd = SPD11;
`endif

    logic [10:0] x11, y11, px11, py11, bx11, by11;
    logic [10:0] idle_sum;
    logic [9:0]  idle_x_d, idle_y_d, pad_top;
    logic [10:0] mv_x_d, cand_y;
    logic [9:0]  mv_y_d;
    logic        mv_dx_d, mv_dy_d;
    logic        hit_bottom, pad_ov, brk_ov, brk_bounce;

    always_comb begin
        x11  = {1'b0, x_q};
        y11  = {1'b0, y_q};
        px11 = {1'b0, paddle_x};
        py11 = {1'b0, paddle_y};
        bx11 = {1'b0, brick_x};
        by11 = {1'b0, brick_y};

        // Ball parked centred on top of the paddle, clamped on screen.
        idle_sum = px11 + HALF_OFF;
        idle_x_d = (idle_sum > X_MAX) ? X_MAX[9:0] : idle_sum[9:0];
        pad_top  = (paddle_y < B10) ? 10'd0 : paddle_y - B10;
        idle_y_d = (pad_top > Y_MAX10) ? Y_MAX10 : pad_top;

        mv_dx_d = dx_q;
        if (!dx_q && x11 <= spd) begin
            mv_x_d  = '0;
            mv_dx_d = 1'b1;
        end else if (dx_q && (x11 + spd + B11) >= W11) begin
            mv_x_d  = X_MAX;
            mv_dx_d = 1'b0;
        end else if (dx_q) begin
            mv_x_d = x11 + spd;
        end else begin
            mv_x_d = x11 - spd;
        end

        // Candidate next y, floored at the top wall so it never wraps.
        if (dy_q)
            cand_y = y11 + spd;
        else if (y11 > spd)
            cand_y = y11 - spd;
        else
            cand_y = '0;

        hit_bottom = dy_q && ((y11 + spd + B11) >= H11);
        pad_ov = (mv_x_d < px11 + PW11) && (px11 < mv_x_d + B11) &&
                 (cand_y < py11 + PH11) && (py11 < cand_y + B11);
        brk_ov = (mv_x_d < bx11 + BW11) && (bx11 < mv_x_d + B11) &&
                 (cand_y < by11 + BH11) && (by11 < cand_y + B11);

        brk_bounce = 1'b0;
        mv_dy_d    = dy_q;
        if (dy_q && pad_ov) begin
            mv_y_d  = pad_top;
            mv_dy_d = 1'b0;
        end else if (brick_alive && brk_ov) begin
            mv_y_d     = cand_y[9:0];
            mv_dy_d    = ~dy_q;
            brk_bounce = 1'b1;
        end else if (!dy_q && y11 <= spd) begin
            mv_y_d  = '0;
            mv_dy_d = 1'b1;
        end else begin
            mv_y_d = cand_y[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b0;
            hit_q   <= 1'b0;
            lost_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef BALL_SPEEDUP_EN
            speed_q  <= SPD11;
            bounce_q <= '0;
`endif
        end else begin
            hit_q  <= 1'b0;
            lost_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
`ifdef BALL_SPEEDUP_EN
                    speed_q  <= SPD11;
                    bounce_q <= '0;
`endif
                    if (tick && launch) begin
                        state_q <= ST_MOVE;
                        dx_q    <= 1'b1;
                        dy_q    <= 1'b0;
                    end else begin
                        x_q <= idle_x_d;
                        y_q <= idle_y_d;
                    end
                end
                ST_MOVE: begin
                    if (tick) begin
                        if (hit_bottom) begin
                            lost_q  <= 1'b1;
                            state_q <= ST_LOST;
                            cnt_q   <= '0;
                        end else begin
                            x_q   <= mv_x_d[9:0];
                            dx_q  <= mv_dx_d;
                            y_q   <= mv_y_d;
                            dy_q  <= mv_dy_d;
                            hit_q <= brk_bounce;
`ifdef BALL_SPEEDUP_EN
                            if (dy_q && pad_ov) begin
                                bounce_q <= bounce_q + 3'd1;
                                if (bounce_q == 3'd7 && speed_q < SPD_MAX)
                                    speed_q <= speed_q + 11'd1;
                            end
`endif
                        end
                    end
                end
                ST_LOST: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign brick_hit = hit_q;
    assign lost      = lost_q;
    assign state     = state_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - Self-checking bench for ball_motion
module tb_ball_motion;
    localparam int SPD = 2;
    localparam int BS  = 8;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int PW  = 64;
    localparam int PH  = 8;
    localparam int BW  = 64;
    localparam int BH  = 16;
    localparam int LT  = 60;

    logic       clk = 1'b0;
    logic       rst, tick, launch, brick_alive;
    logic [9:0] paddle_x, paddle_y, brick_x, brick_y;
    logic [9:0] ball_x, ball_y;
    logic       brick_hit, lost;
    logic [1:0] state;

    ball_motion dut (
        .clk(clk), .rst(rst), .tick(tick), .launch(launch),
        .paddle_x(paddle_x), .paddle_y(paddle_y),
        .brick_x(brick_x), .brick_y(brick_y), .brick_alive(brick_alive),
        .ball_x(ball_x), .ball_y(ball_y), .brick_hit(brick_hit),
        .lost(lost), .state(state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: position plus signed velocity in whole pixels.
    int m_x, m_y, m_vx, m_vy, m_state, m_cnt;
    int m_hit, m_lost;

    function automatic bit boxes_overlap(int ax, int ay, int aw, int ah,
                                         int bx, int by, int bw, int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_step();
        int nx, ny, cy;
        m_hit  = 0;
        m_lost = 0;
        if (!rst) begin
            m_state = 0; m_x = 0; m_y = 0; m_vx = SPD; m_vy = -SPD; m_cnt = 0;
        end else if (m_state == 0) begin
            if (tick && launch) begin
                m_state = 1; m_vx = SPD; m_vy = -SPD;
            end else begin
                m_x = clampi(int'(paddle_x) + PW / 2 - BS / 2, 0, SW - BS);
                m_y = clampi(int'(paddle_y) - BS, 0, SH - BS);
            end
        end else if (m_state == 1) begin
            if (tick) begin
                nx = m_x + m_vx;
                if (nx <= 0) begin
                    nx = 0; m_vx = SPD;
                end else if (nx + BS >= SW) begin
                    nx = SW - BS; m_vx = -SPD;
                end
                ny = m_y + m_vy;
                cy = (ny < 0) ? 0 : ny;
                if (m_vy > 0 && ny + BS >= SH) begin
                    m_lost = 1; m_state = 2; m_cnt = 0;
                end else begin
                    m_x = nx;
                    if (m_vy > 0 && boxes_overlap(nx, cy, BS, BS, int'(paddle_x), int'(paddle_y), PW, PH)) begin
                        m_y = clampi(int'(paddle_y) - BS, 0, SH); m_vy = -SPD;
                    end else if (brick_alive && boxes_overlap(nx, cy, BS, BS, int'(brick_x), int'(brick_y), BW, BH)) begin
                        m_y = cy; m_vy = -m_vy; m_hit = 1;
                    end else if (m_vy < 0 && ny <= 0) begin
                        m_y = 0; m_vy = SPD;
                    end else begin
                        m_y = ny;
                    end
                end
            end
        end else begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == LT) begin
                    m_cnt = 0; m_state = 0;
                end
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        n_total++;
        if (int'(ball_x) != m_x || int'(ball_y) != m_y || int'(state) != m_state ||
            int'(brick_hit) != m_hit || int'(lost) != m_lost) begin
            n_bad++;
            $display("FAIL model at %0t: got x=%0d y=%0d st=%0d hit=%0d lost=%0d expected x=%0d y=%0d st=%0d hit=%0d lost=%0d",
                     $time, ball_x, ball_y, state, brick_hit, lost, m_x, m_y, m_state, m_hit, m_lost);
        end
    endtask

    task automatic tick_n(int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; tick = 1'b0; launch = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic do_launch();
        launch = 1'b1; tick = 1'b1; cyc();
        launch = 1'b0; tick = 1'b0; cyc();
    endtask

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        int         ex;
        int         ey;
    } idle_vec_t;

    idle_vec_t vecs[7];

    initial begin
        int lost_at;
        int pv;

        vecs[0] = '{px: 10'd288,  py: 10'd296, ex: 316, ey: 288};
        vecs[1] = '{px: 10'd0,    py: 10'd8,   ex: 28,  ey: 0};
        vecs[2] = '{px: 10'd604,  py: 10'd472, ex: 632, ey: 464};
        vecs[3] = '{px: 10'd620,  py: 10'd100, ex: 632, ey: 92};
        vecs[4] = '{px: 10'd10,   py: 10'd3,   ex: 38,  ey: 0};
        vecs[5] = '{px: 10'd100,  py: 10'd479, ex: 128, ey: 471};
        vecs[6] = '{px: 10'd1000, py: 10'd900, ex: 632, ey: 472};

        rst = 1'b0; tick = 1'b0; launch = 1'b0; brick_alive = 1'b0;
        paddle_x = 10'd288; paddle_y = 10'd296; brick_x = 10'd500; brick_y = 10'd60;
        m_x = 0; m_y = 0; m_vx = SPD; m_vy = -SPD; m_state = 0; m_cnt = 0; m_hit = 0; m_lost = 0;

        // Reset and release: ball parks on the paddle
        cyc(); cyc();
        chk("reset_state", int'(state), 0);
        chk("reset_x", int'(ball_x), 0);
        chk("reset_y", int'(ball_y), 0);
        rst = 1'b1;
        cyc();
        chk("idle_x", int'(ball_x), 316);
        chk("idle_y", int'(ball_y), 288);
        chk("idle_pulses", int'(brick_hit) + int'(lost), 0);

        // Launch does not move; first move tick goes up-right
        launch = 1'b1; tick = 1'b1; cyc();
        chk("launch_state", int'(state), 1);
        chk("launch_x", int'(ball_x), 316);
        chk("launch_y", int'(ball_y), 288);
        launch = 1'b0; tick = 1'b0; cyc();
        chk("hold_no_tick_x", int'(ball_x), 316);
        tick_n(1);
        chk("first_move_x", int'(ball_x), 318);
        chk("first_move_y", int'(ball_y), 286);

        // Top wall then right wall
        do_reset();
        do_launch();
        tick_n(144);
        chk("top_y", int'(ball_y), 0);
        chk("top_x", int'(ball_x), 604);
        tick_n(14);
        chk("right_x", int'(ball_x), 632);
        chk("right_y", int'(ball_y), 28);
        tick_n(1);
        chk("after_right_x", int'(ball_x), 630);
        chk("after_right_y", int'(ball_y), 30);

        // Brick collision on move tick 107
        brick_alive = 1'b1;
        do_reset();
        do_launch();
        tick_n(106);
        tick = 1'b1; cyc();
        chk("brick_hit_x", int'(ball_x), 530);
        chk("brick_hit_y", int'(ball_y), 74);
        chk("brick_hit_pulse", int'(brick_hit), 1);
        tick = 1'b0; cyc();
        chk("brick_hit_clear", int'(brick_hit), 0);
        tick_n(1);
        chk("after_brick_y", int'(ball_y), 76);

        // Paddle moved away: ball is lost, LOST lasts 60 ticks
        paddle_x = 10'd0;
        lost_at = -1;
        for (int j = 2; j <= 300; j++) begin
            tick = 1'b1; cyc();
            tick = 1'b0;
            if (lost) begin
                lost_at = j;
                break;
            end
            cyc();
        end
        chk("lost_tick", lost_at, 199);
        cyc();
        chk("lost_clear", int'(lost), 0);
        chk("lost_state", int'(state), 2);
        tick_n(59);
        chk("lost_state_59", int'(state), 2);
        tick = 1'b1; cyc();
        chk("back_idle", int'(state), 0);
        tick = 1'b0; cyc();
        chk("track_x", int'(ball_x), 28);
        chk("track_y", int'(ball_y), 288);

        // Reset mid-flight during a tick
        do_launch();
        tick_n(5);
        rst = 1'b0; tick = 1'b1; cyc();
        chk("midrst_state", int'(state), 0);
        chk("midrst_x", int'(ball_x), 0);
        chk("midrst_y", int'(ball_y), 0);
        chk("midrst_pulses", int'(brick_hit) + int'(lost), 0);
        rst = 1'b1; tick = 1'b0;

        // IDLE tracking table, including clamp boundaries
        for (int i = 0; i < 7; i++) begin
            paddle_x = vecs[i].px;
            paddle_y = vecs[i].py;
            cyc();
            chk("tbl_x", int'(ball_x), vecs[i].ex);
            chk("tbl_y", int'(ball_y), vecs[i].ey);
            chk("tbl_state", int'(state), 0);
        end

        // Randomized play against the model
        paddle_x = 10'd288; paddle_y = 10'd420;
        for (int i = 0; i < 15000; i++) begin
            rst    = ($urandom_range(0, 999) != 0);
            tick   = 1'($urandom_range(0, 1));
            launch = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                brick_x     = 10'($urandom_range(0, 576));
                brick_y     = 10'($urandom_range(0, 200));
                brick_alive = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0)
                paddle_y = 10'($urandom_range(380, 460));
            if ($urandom_range(0, 49) == 0) begin
                paddle_x = 10'($urandom_range(0, 576));
            end else if ($urandom_range(0, 7) == 0) begin
                pv = clampi(m_x - int'($urandom_range(0, 60)), 0, 576);
                paddle_x = 10'(pv);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
